branch_predict_btb: RTL and testbench
=====================================

Name: branch_predict_btb

Overview:
- Parametrised successor to the execute-stage branch next-PC unit: it resolves branches and also predicts them.
- Fetch side does a same-cycle lookup into a direct-mapped branch target buffer (BTB), giving a predicted-taken flag and target.
- Execute side resolves each branch using the four-way branch-type encoding, detects mispredictions, issues a registered redirect, updates the BTB, and keeps performance counters.

Parameters:
- XLEN, 32, PC/data width.
- ENTRIES, 16, BTB depth; must be a power of two ≥2. IDX = log2(ENTRIES).
- CTR_BITS, 2, width of the per-entry saturating direction counter.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc_i  in  XLEN  fetch PC to look up.
- pred_taken_o  out  1  prediction for fetch_pc_i (combinational).
- pred_target_o  out  XLEN  predicted target (combinational).
- res_valid_i  in  1  a resolve request is present this cycle.
- res_pc_i  in  XLEN  PC of the resolving instruction.
- res_type_i  in  2  branch type: 00 none, 01 conditional, 10 jal (pc+imm), 11 jalr (register).
- res_imm_i  in  XLEN  immediate offset.
- res_reg_i  in  XLEN  register value (read_data1).
- res_dec_i  in  1  conditional-branch decision.
- res_pred_taken_i  in  1  prediction that travelled with the instruction.
- res_pred_target_i  in  XLEN  predicted target that travelled with the instruction.
- redirect_o  out  1  misprediction redirect (registered).
- redirect_pc_o  out  XLEN  correct next PC (registered).
- branch_cnt_o  out  CNT_W  number of resolved type≠00 instructions.
- mispredict_cnt_o  out  CNT_W  number of mispredictions.

Behaviour:
- Reset, asynchronous on rst_n low:
  - all BTB valid bits cleared;
  - redirect_o=0, redirect_pc_o=0, both counters 0;
  - pred_taken_o=0 for every PC.
- Indexing: idx = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2].
- Entry contents: valid, tag, target, type (1 bit: cond/uncond), counter.
- Lookup (combinational):
  - hit = valid && tag match.
  - pred_taken_o = hit && (uncond || ctr MSB).
  - pred_target_o = entry target on a hit, otherwise fetch_pc_i+4.
- Actual outcome, computed combinationally from the res_* inputs, modulo 2^XLEN:
  - 00 → not taken, next=pc+4;
  - 01 → taken = res_dec_i, next = taken ? pc+imm : pc+4;
  - 10 → taken, next=pc+imm;
  - 11 → taken, next=res_reg_i exactly (no bit masking).
- Mispredict = res_valid_i && (res_pred_taken_i≠taken || (taken && res_pred_target_i≠next)).
- Redirect: on the clock edge, redirect_o<=mispredict and redirect_pc_o<=next if mispredict, else redirect_pc_o holds its value. Latency is 1 cycle; redirect_o is a single-cycle pulse per resolve.
- BTB update on the clock edge when res_valid_i:
  - type 00: if res_pc_i hits, invalidate that entry (aliased non-branch); otherwise no change.
  - type 01, hit: counter ± saturating (increment if taken, decrement if not); target<=next when taken.
  - type 01, miss: allocate only if taken, with ctr=weakly taken (MSB=1, rest 0); overwrite whatever entry is at idx.
  - types 10/11: allocate or overwrite, uncond=1, target=next.
- Counters: branch_cnt_o increments for each res_valid_i with type≠00; mispredict_cnt_o increments per mispredict. Both saturate at all-ones and do not wrap.
- Lookup and update to the same idx in the same cycle: the lookup returns the pre-update contents; the new contents are visible the next cycle.
- res_valid_i=0: no state change except that redirect_o<=0.
- Reset mid-operation clears a pending or active redirect immediately, without waiting for a clock edge.

Test Plan:
- Reset, then fetch_pc_i=0x100 → pred_taken_o=0, pred_target_o=0x104; redirect_o=0; both counters 0.
- Resolve pc=0x100, type 01, dec=1, imm=0x40, pred_taken=0 → next cycle redirect_o=1, redirect_pc_o=0x140, mispredict_cnt=1, branch_cnt=1; then fetch 0x100 → pred_taken_o=1, target 0x140.
- Resolve the same branch with dec=0, pred_taken=1 → redirect_pc_o=0x104; counter 10→01; fetch 0x100 → pred_taken_o=0. A second not-taken resolve → counter 00 and saturates there.
- jalr at pc=0x200 with reg=0x8000_1234, no prediction → redirect to 0x80001234. Repeat with reg=0x80001238 and pred_target=0x80001234 → mispredict, redirect 0x80001238, entry target updated. A third resolve with a correct prediction → redirect_o=0.
- Alias: allocate 0x100, then resolve type 10 at 0x140 (same idx 0) → fetch 0x100 misses, fetch 0x140 hits. Resolve type 00 at 0x140 with pred_taken=1 → redirect to 0x144 and the entry is invalidated.
- Drop rst_n low the cycle after a mispredict resolve → redirect_o falls to 0 without a clock edge. Preload counters at 0xFFFF → further events hold them at 0xFFFF.

Source files
------------

// File: rtl/branch_predict_btb.sv
// Branch resolve and predict unit: direct-mapped BTB lookup on the fetch side,
// branch resolution, registered mispredict redirect, BTB update and perf counters.
module branch_predict_btb #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   fetch_pc_i,
    output logic              pred_taken_o,
    output logic [XLEN-1:0]   pred_target_o,
    input  logic              res_valid_i,
    input  logic [XLEN-1:0]   res_pc_i,
    input  logic [1:0]        res_type_i,
    input  logic [XLEN-1:0]   res_imm_i,
    input  logic [XLEN-1:0]   res_reg_i,
    input  logic              res_dec_i,
    input  logic              res_pred_taken_i,
    input  logic [XLEN-1:0]   res_pred_target_i,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispredict_cnt_o
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(1) << (CTR_BITS - 1);

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_COND = 2'b01;
    localparam logic [1:0] TYPE_JAL  = 2'b10;

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic                uncond_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX-1:0]   f_idx, r_idx;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic             f_hit, r_hit;
    logic             taken;
    logic [XLEN-1:0]  next_pc;
    logic             mispredict;

    // Fetch-side lookup always sees the pre-update contents of the array.
    assign f_idx         = fetch_pc_i[IDX+1:2];
    assign f_tag         = fetch_pc_i[XLEN-1:IDX+2];
    assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken_o  = f_hit && (uncond_q[f_idx] || ctr_q[f_idx][CTR_BITS-1]);
    assign pred_target_o = f_hit ? target_q[f_idx] : fetch_pc_i + XLEN'(4);

    assign r_idx = res_pc_i[IDX+1:2];
    assign r_tag = res_pc_i[XLEN-1:IDX+2];
    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    always_comb begin
        taken   = 1'b0;
        next_pc = res_pc_i + XLEN'(4);
        case (res_type_i)
            TYPE_NONE: ;
            TYPE_COND: begin
                taken = res_dec_i;
                if (res_dec_i) next_pc = res_pc_i + res_imm_i;
            end
            TYPE_JAL: begin
                taken   = 1'b1;
                next_pc = res_pc_i + res_imm_i;
            end
            default: begin
                taken   = 1'b1;
                next_pc = res_reg_i;
            end
        endcase
    end

    assign mispredict = res_valid_i &&
                        ((res_pred_taken_i != taken) ||
                         (taken && (res_pred_target_i != next_pc)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_o       <= 1'b0;
            redirect_pc_o    <= '0;
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            redirect_o <= mispredict;
            if (mispredict) redirect_pc_o <= next_pc;
            if (res_valid_i && (res_type_i != TYPE_NONE) && (branch_cnt_o != '1))
                branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            if (mispredict && (mispredict_cnt_o != '1))
                mispredict_cnt_o <= mispredict_cnt_o + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                uncond_q[i] <= 1'b0;
                ctr_q[i]    <= '0;
            end
        end else if (res_valid_i) begin
            case (res_type_i)
                TYPE_NONE: begin
                    // A non-branch that hits means the entry belongs to an alias.
                    if (r_hit) valid_q[r_idx] <= 1'b0;
                end
                TYPE_COND: begin
                    if (r_hit) begin
                        if (taken && (ctr_q[r_idx] != '1))
                            ctr_q[r_idx] <= ctr_q[r_idx] + CTR_BITS'(1);
                        else if (!taken && (ctr_q[r_idx] != '0))
                            ctr_q[r_idx] <= ctr_q[r_idx] - CTR_BITS'(1);
                        if (taken) target_q[r_idx] <= next_pc;
                    end else if (taken) begin
                        valid_q[r_idx]  <= 1'b1;
                        tag_q[r_idx]    <= r_tag;
                        target_q[r_idx] <= next_pc;
                        uncond_q[r_idx] <= 1'b0;
                        ctr_q[r_idx]    <= CTR_WEAK_T;
                    end
                end
                default: begin
                    valid_q[r_idx]  <= 1'b1;
                    tag_q[r_idx]    <= r_tag;
                    target_q[r_idx] <= next_pc;
                    uncond_q[r_idx] <= 1'b1;
                    ctr_q[r_idx]    <= CTR_WEAK_T;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predict_btb.sv
// Self-checking bench for branch_predict_btb: scoreboard of expected redirects
// and counter values, plus direct checks of the combinational fetch lookup.
module tb_branch_predict_btb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [1:0]  res_type;
    logic [31:0] res_imm;
    logic [31:0] res_reg;
    logic        res_dec;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt;
    logic [15:0] mispredict_cnt;

    typedef struct {
        logic        mis;
        logic [31:0] pc;
        logic        br;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_rpc  = 32'h0;
    logic [15:0] exp_br   = 16'h0;
    logic [15:0] exp_mis  = 16'h0;

    always #5 clk = ~clk;

    branch_predict_btb dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_pc_i        (fetch_pc),
        .pred_taken_o      (pred_taken),
        .pred_target_o     (pred_target),
        .res_valid_i       (res_valid),
        .res_pc_i          (res_pc),
        .res_type_i        (res_type),
        .res_imm_i         (res_imm),
        .res_reg_i         (res_reg),
        .res_dec_i         (res_dec),
        .res_pred_taken_i  (res_pred_taken),
        .res_pred_target_i (res_pred_target),
        .redirect_o        (redirect),
        .redirect_pc_o     (redirect_pc),
        .branch_cnt_o      (branch_cnt),
        .mispredict_cnt_o  (mispredict_cnt)
    );

    task automatic drive(input logic [31:0] pc, input logic [1:0] ty,
                         input logic [31:0] imm, input logic [31:0] rg,
                         input logic dec, input logic pt, input logic [31:0] ptgt,
                         input logic exp_mis_i, input logic [31:0] exp_pc_i);
        exp_t e;
        res_valid       = 1'b1;
        res_pc          = pc;
        res_type        = ty;
        res_imm         = imm;
        res_reg         = rg;
        res_dec         = dec;
        res_pred_taken  = pt;
        res_pred_target = ptgt;
        e.mis = exp_mis_i;
        e.pc  = exp_pc_i;
        e.br  = (ty != 2'b00);
        sb.push_back(e);
    endtask

    // One clock; pops the expectation for the resolve that was presented, if any.
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.mis) exp_rpc = e.pc;
            if (e.br)  exp_br  = exp_br + 16'd1;
            if (e.mis) exp_mis = exp_mis + 16'd1;
        end else begin
            e.mis = 1'b0;
        end
        n_checks++;
        if (redirect !== e.mis) $display("FAIL %s redirect: got %0b want %0b", tag, redirect, e.mis);
        else n_pass++;
        n_checks++;
        if (redirect_pc !== exp_rpc) $display("FAIL %s redirect_pc: got %h want %h", tag, redirect_pc, exp_rpc);
        else n_pass++;
        n_checks++;
        if (branch_cnt !== exp_br) $display("FAIL %s branch_cnt: got %0d want %0d", tag, branch_cnt, exp_br);
        else n_pass++;
        n_checks++;
        if (mispredict_cnt !== exp_mis) $display("FAIL %s mispredict_cnt: got %0d want %0d", tag, mispredict_cnt, exp_mis);
        else n_pass++;
    endtask

    task automatic resolve(input string tag, input logic [31:0] pc, input logic [1:0] ty,
                           input logic [31:0] imm, input logic [31:0] rg,
                           input logic dec, input logic pt, input logic [31:0] ptgt,
                           input logic exp_mis_i, input logic [31:0] exp_pc_i);
        drive(pc, ty, imm, rg, dec, pt, ptgt, exp_mis_i, exp_pc_i);
        step(tag);
        res_valid = 1'b0;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] pc,
                               input logic exp_t_i, input logic [31:0] exp_tgt);
        fetch_pc = pc;
        #1;
        n_checks++;
        if (pred_taken !== exp_t_i) $display("FAIL %s pred_taken: got %0b want %0b", tag, pred_taken, exp_t_i);
        else n_pass++;
        n_checks++;
        if (pred_target !== exp_tgt) $display("FAIL %s pred_target: got %h want %h", tag, pred_target, exp_tgt);
        else n_pass++;
    endtask

    task automatic test_reset();
        check_fetch("reset_fetch", 32'h100, 1'b0, 32'h104);
        step("reset_idle");
    endtask

    task automatic test_cond();
        resolve("cond_taken_miss", 32'h100, 2'b01, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h140);
        check_fetch("cond_alloc", 32'h100, 1'b1, 32'h140);
        resolve("cond_nt_mis", 32'h100, 2'b01, 32'h40, 32'h0, 1'b0, 1'b1, 32'h140, 1'b1, 32'h104);
        check_fetch("cond_ctr01", 32'h100, 1'b0, 32'h140);
        resolve("cond_nt_ok1", 32'h100, 2'b01, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        resolve("cond_nt_ok2", 32'h100, 2'b01, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        // From a saturated 00 a single taken resolve must only reach 01.
        resolve("cond_t_from00", 32'h100, 2'b01, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h140);
        check_fetch("cond_sat_low", 32'h100, 1'b0, 32'h140);
    endtask

    task automatic test_jalr();
        resolve("jalr_first", 32'h200, 2'b11, 32'h0, 32'h8000_1234, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_1234);
        check_fetch("jalr_alloc", 32'h200, 1'b1, 32'h8000_1234);
        resolve("jalr_wrong_tgt", 32'h200, 2'b11, 32'h0, 32'h8000_1238, 1'b0, 1'b1, 32'h8000_1234, 1'b1, 32'h8000_1238);
        check_fetch("jalr_update", 32'h200, 1'b1, 32'h8000_1238);
        resolve("jalr_correct", 32'h200, 2'b11, 32'h0, 32'h8000_1238, 1'b0, 1'b1, 32'h8000_1238, 1'b0, 32'h0);
    endtask

    task automatic test_alias();
        resolve("alias_jal_a", 32'h100, 2'b10, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h120);
        resolve("alias_jal_b", 32'h140, 2'b10, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h160);
        check_fetch("alias_miss_a", 32'h100, 1'b0, 32'h104);
        check_fetch("alias_hit_b", 32'h140, 1'b1, 32'h160);
        resolve("alias_none_inv", 32'h140, 2'b00, 32'h20, 32'h0, 1'b0, 1'b1, 32'h160, 1'b1, 32'h144);
        check_fetch("alias_invalid", 32'h140, 1'b0, 32'h144);
        resolve("none_nohit", 32'h180, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        fetch_pc = 32'h304;
        drive(32'h304, 2'b10, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h30c);
        #1;
        n_checks++;
        if (pred_taken !== 1'b0) $display("FAIL same_cycle_pre pred_taken: got %0b want 0", pred_taken);
        else n_pass++;
        step("b2b_first");
        drive(32'h408, 2'b01, 32'hffff_fff0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h3f8);
        n_checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h30c)
            $display("FAIL same_cycle_post pred: got %0b/%h want 1/0000030c", pred_taken, pred_target);
        else n_pass++;
        step("b2b_second");
        res_valid = 1'b0;
        step("b2b_idle");
        check_fetch("b2b_cond_alloc", 32'h408, 1'b1, 32'h3f8);
    endtask

    task automatic test_async_reset();
        resolve("rst_mis", 32'h500, 2'b10, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h510);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (redirect !== 1'b0 || redirect_pc !== 32'h0)
            $display("FAIL async_rst redirect: got %0b/%h want 0/00000000", redirect, redirect_pc);
        else n_pass++;
        n_checks++;
        if (branch_cnt !== 16'h0 || mispredict_cnt !== 16'h0)
            $display("FAIL async_rst counters: got %h/%h want 0000/0000", branch_cnt, mispredict_cnt);
        else n_pass++;
        check_fetch("async_rst_btb", 32'h500, 1'b0, 32'h504);
        exp_rpc = 32'h0;
        exp_br  = 16'h0;
        exp_mis = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        res_valid       = 1'b1;
        res_pc          = 32'h600;
        res_type        = 2'b10;
        res_imm         = 32'h10;
        res_pred_taken  = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        n_checks++;
        if (branch_cnt !== 16'hffff) $display("FAIL sat branch_cnt: got %h want ffff", branch_cnt);
        else n_pass++;
        n_checks++;
        if (mispredict_cnt !== 16'hffff) $display("FAIL sat mispredict_cnt: got %h want ffff", mispredict_cnt);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (branch_cnt !== 16'hffff || mispredict_cnt !== 16'hffff)
            $display("FAIL sat_hold counters: got %h/%h want ffff/ffff", branch_cnt, mispredict_cnt);
        else n_pass++;
        res_valid = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        fetch_pc        = 32'h0;
        res_valid       = 1'b0;
        res_pc          = 32'h0;
        res_type        = 2'b00;
        res_imm         = 32'h0;
        res_reg         = 32'h0;
        res_dec         = 1'b0;
        res_pred_taken  = 1'b0;
        res_pred_target = 32'h0;
        #22;
        rst_n = 1'b1;
        test_reset();
        test_cond();
        test_jalr();
        test_alias();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
